memory_word_port: RTL and testbench

- Sits directly downstream of the address register file.
- Takes the 16-bit address driven on the register file's OutD bus and performs one 16-bit word read or write to the byte-wide system memory, as two sequential byte accesses.
- Little-endian: low byte at Address, high byte at Address+1.
- The control unit starts a transfer with a Req/Busy/Done handshake; read data is returned on RdData.

---
 rtl/memory_word_port.sv | 129 ++++++++++++
 tb/tb_memory_word_port.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_word_port.sv
// 16-bit word access to byte-wide memory as two little-endian byte cycles.
// Optional: define ALIGN_CHECK_EN to reject odd addresses with Err.
module memory_word_port #(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [15:0]       WrData,
  input  logic              Req,
  input  logic              Wr,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [15:0]       RdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWrData,
  output logic              MemCS,
  output logic              MemWE,
  input  logic [7:0]        MemRdData
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_LO  = 3'd1;
  localparam logic [2:0] WR_HI  = 3'd2;
  localparam logic [2:0] RD_LO  = 3'd3;
  localparam logic [2:0] RD_HI  = 3'd4;
  localparam logic [2:0] RD_CAP = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  generate
    if (MEM_LAT != 1) begin : g_lat_chk
      $error("memory_word_port: only MEM_LAT=1 is supported");
    end
  endgenerate

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] a_inc;
  logic [7:0]        d_hi;
  logic              odd;

  assign Busy  = (state != IDLE);
  assign a_inc = a + ADDR_W'(1);

`ifdef ALIGN_CHECK_EN
  assign odd = Address[0];
`else
  assign odd = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (Req) nxt = odd ? DONE : (Wr ? WR_LO : RD_LO);
      end
      WR_LO:   nxt = WR_HI;
      WR_HI:   nxt = DONE;
      RD_LO:   nxt = RD_HI;
      RD_HI:   nxt = RD_CAP;
      RD_CAP:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // memory-side outputs are loaded from nxt so they are valid during the state
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      a         <= '0;
      d_hi      <= '0;
      Done      <= 1'b0;
      MemCS     <= 1'b0;
      MemWE     <= 1'b0;
      MemAddr   <= '0;
      MemWrData <= '0;
      RdData    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && Req) begin
        a    <= Address;
        d_hi <= WrData[15:8];
      end
      Done      <= (nxt == DONE);
      MemCS     <= 1'b0;
      MemWE     <= 1'b0;
      MemWrData <= '0;
      case (nxt)
        WR_LO: begin
          MemCS     <= 1'b1;
          MemWE     <= 1'b1;
          MemAddr   <= Address;
          MemWrData <= WrData[7:0];
        end
        WR_HI: begin
          MemCS     <= 1'b1;
          MemWE     <= 1'b1;
          MemAddr   <= a_inc;
          MemWrData <= d_hi;
        end
        RD_LO: begin
          MemCS   <= 1'b1;
          MemAddr <= Address;
        end
        RD_HI: begin
          MemCS   <= 1'b1;
          MemAddr <= a_inc;
        end
        default: ;
      endcase
      if (state == RD_HI)  RdData[7:0]  <= MemRdData;
      if (state == RD_CAP) RdData[15:8] <= MemRdData;
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge Clock) begin
    if (!Reset) Err <= 1'b0;
    else        Err <= (state == IDLE) && (nxt == DONE);
  end
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_word_port.sv
// Directed bench for memory_word_port with a 1-cycle-latency byte memory.
// Define ALIGN_CHECK_EN on both files to exercise the odd-address path.
module tb_memory_word_port;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Address;
  logic [15:0] WrData;
  logic        Req;
  logic        Wr;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [15:0] RdData;
  logic [15:0] MemAddr;
  logic [7:0]  MemWrData;
  logic        MemCS;
  logic        MemWE;
  logic [7:0]  MemRdData = 8'h00;

  logic [7:0] mem [0:65535];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cs_cnt = 0;

  memory_word_port #(.ADDR_W(16), .MEM_LAT(1)) dut (
    .Clock(Clock), .Reset(Reset),
    .Address(Address), .WrData(WrData),
    .Req(Req), .Wr(Wr),
    .Busy(Busy), .Done(Done), .Err(Err),
    .RdData(RdData), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemCS(MemCS),
    .MemWE(MemWE), .MemRdData(MemRdData)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemCS === 1'b1 && MemWE === 1'b1) mem[MemAddr] <= MemWrData;
    if (MemCS === 1'b1 && MemWE === 1'b0) MemRdData <= mem[MemAddr];
    if (Done === 1'b1) done_cnt++;
    if (Err === 1'b1) err_cnt++;
    if (MemCS === 1'b1) cs_cnt++;
  end

  // one transfer plus an 8-cycle observation window
  task automatic xfer(
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic        hold,
    output int          first_done,
    output int          ndone,
    output int          nbusy,
    output int          ncs,
    output int          nerr,
    output logic [15:0] rd_done
  );
    int d0, c0, e0;
    @(negedge Clock);
    Req = 1'b1; Wr = wr; Address = addr; WrData = data;
    d0 = done_cnt; c0 = cs_cnt; e0 = err_cnt;
    first_done = -1; nbusy = 0; rd_done = 16'hxxxx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        Address = 16'h5555; WrData = 16'hAAAA; Wr = ~wr;
      end
      if (Busy === 1'b1) nbusy++;
      if (Done === 1'b1 && first_done < 0) begin
        first_done = k; rd_done = RdData;
      end
      Req = hold && (Busy === 1'b1);
    end
    Req = 1'b0;
    ndone = done_cnt - d0;
    ncs = cs_cnt - c0;
    nerr = err_cnt - e0;
  endtask

  task automatic test_reset;
    int c0;
    Reset = 1'b0; Req = 1'b0; Wr = 1'b0;
    Address = '0; WrData = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got %b want 0", Busy);
    end
    total++;
    if (Done !== 1'b0) begin
      bad++; $display("FAIL rst_done: got %b want 0", Done);
    end
    total++;
    if (Err !== 1'b0) begin
      bad++; $display("FAIL rst_err: got %b want 0", Err);
    end
    total++;
    if (MemCS !== 1'b0 || MemWE !== 1'b0) begin
      bad++;
      $display("FAIL rst_cs_we: got %b%b want 00", MemCS, MemWE);
    end
    total++;
    if (MemAddr !== 16'h0000) begin
      bad++; $display("FAIL rst_addr: got %h want 0000", MemAddr);
    end
    total++;
    if (MemWrData !== 8'h00) begin
      bad++; $display("FAIL rst_wdata: got %h want 00", MemWrData);
    end
    total++;
    if (RdData !== 16'h0000) begin
      bad++; $display("FAIL rst_rdata: got %h want 0000", RdData);
    end
    c0 = cs_cnt;
    repeat (5) @(negedge Clock);
    total++;
    if (cs_cnt - c0 !== 0) begin
      bad++; $display("FAIL idle_cs: got %0d want 0", cs_cnt - c0);
    end
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL idle_busy: got %b want 0", Busy);
    end
  endtask

  task automatic test_write;
    int fd, nd, nb, nc, ne;
    logic [15:0] rd;
    xfer(1'b1, 16'h0040, 16'hBEEF, 1'b0, fd, nd, nb, nc, ne, rd);
    total++;
    if (fd !== 3) begin
      bad++; $display("FAIL wr_latency: got %0d want 3", fd);
    end
    total++;
    if (nd !== 1) begin
      bad++; $display("FAIL wr_done_cnt: got %0d want 1", nd);
    end
    total++;
    if (nb !== 3) begin
      bad++; $display("FAIL wr_busy: got %0d want 3", nb);
    end
    total++;
    if (nc !== 2) begin
      bad++; $display("FAIL wr_cs: got %0d want 2", nc);
    end
    total++;
    if (ne !== 0) begin
      bad++; $display("FAIL wr_err: got %0d want 0", ne);
    end
    total++;
    if (mem[16'h0040] !== 8'hEF) begin
      bad++; $display("FAIL wr_lo: got %h want ef", mem[16'h0040]);
    end
    total++;
    if (mem[16'h0041] !== 8'hBE) begin
      bad++; $display("FAIL wr_hi: got %h want be", mem[16'h0041]);
    end
    total++;
    if (RdData !== 16'h0000) begin
      bad++; $display("FAIL wr_rdata: got %h want 0000", RdData);
    end
    total++;
    if (MemAddr !== 16'h0041 || MemWrData !== 8'h00) begin
      bad++;
      $display("FAIL wr_hold: got %h/%h want 0041/00", MemAddr, MemWrData);
    end
  endtask

  task automatic test_read_hold;
    int fd, nd, nb, nc, ne;
    logic [15:0] rd;
    xfer(1'b0, 16'h0040, 16'h0000, 1'b1, fd, nd, nb, nc, ne, rd);
    total++;
    if (fd !== 4) begin
      bad++; $display("FAIL rd_latency: got %0d want 4", fd);
    end
    total++;
    if (rd !== 16'hBEEF) begin
      bad++; $display("FAIL rd_data_at_done: got %h want beef", rd);
    end
    total++;
    if (nd !== 1) begin
      bad++; $display("FAIL rd_done_cnt: got %0d want 1", nd);
    end
    total++;
    if (nb !== 4) begin
      bad++; $display("FAIL rd_busy: got %0d want 4", nb);
    end
    total++;
    if (nc !== 2) begin
      bad++; $display("FAIL rd_cs: got %0d want 2", nc);
    end
    total++;
    if (RdData !== 16'hBEEF) begin
      bad++; $display("FAIL rd_held: got %h want beef", RdData);
    end
  endtask

  task automatic test_wrap;
    int fd, nd, nb, nc, ne;
    logic [15:0] rd;
`ifndef ALIGN_CHECK_EN
    xfer(1'b1, 16'hFFFF, 16'h1234, 1'b0, fd, nd, nb, nc, ne, rd);
    total++;
    if (mem[16'hFFFF] !== 8'h34) begin
      bad++; $display("FAIL wrap_lo: got %h want 34", mem[16'hFFFF]);
    end
    total++;
    if (mem[16'h0000] !== 8'h12) begin
      bad++; $display("FAIL wrap_hi: got %h want 12", mem[16'h0000]);
    end
    xfer(1'b0, 16'hFFFF, 16'h0000, 1'b0, fd, nd, nb, nc, ne, rd);
    total++;
    if (rd !== 16'h1234 || fd !== 4) begin
      bad++;
      $display("FAIL wrap_rd: got %h@%0d want 1234@4", rd, fd);
    end
`else
    xfer(1'b1, 16'hFFFE, 16'h1234, 1'b0, fd, nd, nb, nc, ne, rd);
    total++;
    if (mem[16'hFFFE] !== 8'h34 || mem[16'hFFFF] !== 8'h12) begin
      bad++;
      $display("FAIL even_wr: got %h%h want 1234",
               mem[16'hFFFF], mem[16'hFFFE]);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int d0, fd, nd, nb, nc, ne;
    logic [15:0] rd;
    @(negedge Clock);
    Req = 1'b1; Wr = 1'b0; Address = 16'h0040;
    d0 = done_cnt;
    @(negedge Clock);
    Req = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    total++;
    if (Busy !== 1'b0 || MemCS !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle: got busy=%b cs=%b want 0 0", Busy, MemCS);
    end
    total++;
    if (RdData !== 16'h0000) begin
      bad++; $display("FAIL mid_rdata: got %h want 0000", RdData);
    end
    Reset = 1'b1;
    repeat (4) @(negedge Clock);
    total++;
    if (done_cnt - d0 !== 0) begin
      bad++; $display("FAIL mid_done: got %0d want 0", done_cnt - d0);
    end
    xfer(1'b0, 16'h0040, 16'h0000, 1'b0, fd, nd, nb, nc, ne, rd);
    total++;
    if (rd !== 16'hBEEF || fd !== 4) begin
      bad++;
      $display("FAIL mid_reread: got %h@%0d want beef@4", rd, fd);
    end
  endtask

  task automatic test_odd;
    int fd, nd, nb, nc, ne;
    logic [15:0] rd;
    xfer(1'b0, 16'h0041, 16'h0000, 1'b0, fd, nd, nb, nc, ne, rd);
`ifdef ALIGN_CHECK_EN
    total++;
    if (fd !== 1 || nd !== 1) begin
      bad++; $display("FAIL odd_done: got %0d/%0d want 1/1", fd, nd);
    end
    total++;
    if (ne !== 1) begin
      bad++; $display("FAIL odd_err: got %0d want 1", ne);
    end
    total++;
    if (nc !== 0) begin
      bad++; $display("FAIL odd_cs: got %0d want 0", nc);
    end
    total++;
    if (RdData !== 16'hBEEF) begin
      bad++; $display("FAIL odd_rdata: got %h want beef", RdData);
    end
`else
    total++;
    if (fd !== 4 || nd !== 1) begin
      bad++; $display("FAIL odd_done: got %0d/%0d want 4/1", fd, nd);
    end
    total++;
    if (ne !== 0) begin
      bad++; $display("FAIL odd_err: got %0d want 0", ne);
    end
    total++;
    if (nc !== 2) begin
      bad++; $display("FAIL odd_cs: got %0d want 2", nc);
    end
    total++;
    if (RdData !== 16'h00BE) begin
      bad++; $display("FAIL odd_rdata: got %h want 00be", RdData);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read_hold();
    test_wrap();
    test_reset_mid();
    test_odd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
